// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_s;

    typedef enum logic [1:0] {
        FETCH_BOOT,
        FETCH_RUN,
        FETCH_DRAIN
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; flush beats push/pop, push+pop on full is allowed.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  T                             din,
    input  logic                         pop,
    input  logic                         flush,
    output T                             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T               mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers {pc,inst} for decode and drops stale responses after a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 2;

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] drop;
    logic [CW-1:0] drop_nxt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] credits_used;
    logic          grant;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pcq_full;
    logic          pcq_empty;
    logic [31:0]   rsp_pc;
    fetch_entry_s  head;
    fetch_entry_s  push_entry;

    assign credits_used = SW'(outstanding) + SW'(drop) + SW'(fifo_count);
    assign grant        = imem_req_o && imem_gnt_i;
    assign rsp_drop     = imem_rvalid_i && (drop != '0);
    assign rsp_keep     = imem_rvalid_i && (drop == '0) && !redirect_i && !pcq_empty;
    assign pop          = valid_o && ready_i;
    assign push_entry   = '{pc: rsp_pc, inst: imem_rdata_i};
    assign imem_addr_o  = fetch_pc;

    // Stale responses include any still owed from an earlier redirect, so drop accumulates.
    always_comb begin
        drop_nxt = drop;
        if (redirect_i)
            drop_nxt = drop + outstanding - CW'(imem_rvalid_i);
        else if (rsp_drop)
            drop_nxt = drop - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH_BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_BOOT:  state_nxt = FETCH_RUN;
            FETCH_RUN:   if (redirect_i && drop_nxt != '0) state_nxt = FETCH_DRAIN;
            FETCH_DRAIN: if (drop_nxt == '0)               state_nxt = FETCH_RUN;
            default:     state_nxt = FETCH_BOOT;
        endcase
    end

    // Full flags are implied by the credit sum; they stay in as a guard.
    always_comb begin
        imem_req_o = (state != FETCH_BOOT) && !redirect_i &&
                     (credits_used < SW'(FIFO_DEPTH)) && !fifo_full && !pcq_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else begin
            drop <= drop_nxt;
            if (redirect_i)
                fetch_pc <= redirect_target_i & ~32'h3;
            else if (grant)
                fetch_pc <= fetch_pc + 32'd4;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [31:0])) u_pcq (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   (fetch_pc),
        .pop   (rsp_keep),
        .flush (redirect_i),
        .dout  (rsp_pc),
        .count (outstanding),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_s)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .din   (push_entry),
        .pop   (pop),
        .flush (redirect_i),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign valid_o = !fifo_empty;
    assign inst_o  = valid_o ? head.inst : 32'h0;
    assign pc_o    = valid_o ? head.pc   : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an in-order memory model feeds the DUT, every grant
// queues the expected {pc,inst}, every decode pop is compared against the queue head.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i, redirect_i, ready_i, valid_o;
    logic [31:0] imem_addr_o, imem_rdata_i, redirect_target_i, inst_o, pc_o;
    logic        b_req, b_gnt, b_rvalid, b_valid;
    logic [31:0] b_addr, b_rdata, b_inst, b_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
        .ready_i(ready_i), .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(FD)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(b_gnt),
        .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
        .redirect_i(1'b0), .redirect_target_i(32'h0),
        .ready_i(1'b1), .valid_o(b_valid), .inst_o(b_inst), .pc_o(b_pc)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } mrsp_t;

    int           checks = 0;
    int           errors = 0;
    int           cycn   = 0;
    int           lat    = 1;
    int           gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
    mrsp_t        memq[$];
    fetch_entry_s expq[$];
    logic [31:0]  gaddr_q[$];
    logic [31:0]  popq[$];
    logic         b_pend = 1'b0;
    logic [31:0]  b_pend_addr = 32'h0;
    logic [31:0]  b_gq[$];
    logic [31:0]  b_pq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    // One clock: drive at negedge, observe/score 1ns later, then let the posedge land.
    task automatic step(input logic redir, input logic [31:0] tgt);
        fetch_entry_s e;
        @(negedge clk);
        redirect_i        = redir;
        redirect_target_i = tgt;
        ready_i           = ($urandom_range(99) < rdy_pct);
        imem_gnt_i        = ($urandom_range(99) < gnt_pct);
        if (memq.size() > 0 && memq[0].due <= cycn && $urandom_range(99) < rv_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memq[0].data;
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
        end
        b_gnt    = 1'b1;
        b_rvalid = b_pend;
        b_rdata  = mem_word(b_pend_addr);
        #1;
        if (!valid_o) chk("idle_zero", pc_o | inst_o, 32'h0);
        if (rst) begin
            memq.delete();
            expq.delete();
            b_pend = 1'b0;
        end else begin
            chk("credit", 32'(32'(dut.outstanding) + 32'(dut.drop) + 32'(dut.fifo_count) <= FD), 32'd1);
            if (valid_o && ready_i) begin
                if (expq.size() == 0) begin
                    chk("pop_unexp", 32'(expq.size()), 32'd1);
                end else begin
                    e = expq.pop_front();
                    chk("pc", pc_o, e.pc);
                    chk("inst", inst_o, e.inst);
                end
                popq.push_back(pc_o);
            end
            if (redir) expq.delete();
            if (imem_rvalid_i) void'(memq.pop_front());
            if (imem_req_o && imem_gnt_i) begin
                memq.push_back('{data: mem_word(imem_addr_o), due: cycn + lat});
                expq.push_back('{pc: imem_addr_o, inst: mem_word(imem_addr_o)});
                gaddr_q.push_back(imem_addr_o);
            end
            if (b_valid) begin
                chk("b_inst", b_inst, mem_word(b_pc));
                b_pq.push_back(b_pc);
            end
            b_pend      = b_req && b_gnt;
            b_pend_addr = b_addr;
            if (b_req && b_gnt) b_gq.push_back(b_addr);
        end
        @(posedge clk);
        cycn++;
    endtask

    initial begin
        int n;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        redirect_i = 0; redirect_target_i = 0; ready_i = 0;
        b_gnt = 0; b_rvalid = 0; b_rdata = 0;

        // Reset state
        step(0, 0); step(0, 0);
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_req", 32'(imem_req_o), 0);
        chk("rst_state", 32'(dut.state), 32'(FETCH_BOOT));
        chk("rst_pc", dut.fetch_pc, 32'h0);
        chk("rst_b_pc", dut_b.fetch_pc, 32'hFFFF_FFF8);
        chk("rst_b_req", 32'(b_req), 0);

        // 1: first valid after third edge, sequential addresses
        rst = 0;
        step(0, 0); #1;
        chk("t1_v1", 32'(valid_o), 0);
        chk("t1_run", 32'(dut.state), 32'(FETCH_RUN));
        step(0, 0); #1;
        chk("t1_v2", 32'(valid_o), 0);
        step(0, 0); #1;
        chk("t1_v3", 32'(valid_o), 1);
        chk("t1_pc0", pc_o, 32'h0);
        chk("t1_inst0", inst_o, mem_word(32'h0));
        repeat (20) step(0, 0);
        for (int i = 0; i < 5; i++) chk("t1_addr", gaddr_q[i], 32'(i * 4));
        chk("t1_rate", 32'(popq.size() >= 10), 1);

        // 2: decode stalls, buffer fills to depth, requests stop
        rdy_pct = 0;
        repeat (10) step(0, 0);
        #1;
        chk("t2_buffered", 32'(expq.size()), FD);
        chk("t2_fifo_cnt", 32'(dut.fifo_count), FD);
        chk("t2_req_off", 32'(imem_req_o), 0);
        chk("t2_valid", 32'(valid_o), 1);
        rdy_pct = 100;
        popq.delete();
        repeat (12) step(0, 0);
        for (int i = 1; i < popq.size(); i++) chk("t2_seq", popq[i], popq[i-1] + 32'd4);

        // 3: redirect with two requests in flight
        lat = 3;
        n = 0;
        while (!(memq.size() == 2 && memq[0].due > cycn) && n < 50) begin step(0, 0); n++; end
        chk("t3_setup", 32'(n < 50), 1);
        gaddr_q.delete();
        popq.delete();
        step(1, 32'h0000_0102); #1;
        chk("t3_drain", 32'(dut.state), 32'(FETCH_DRAIN));
        chk("t3_vld_off", 32'(valid_o), 0);
        n = 0;
        while (popq.size() == 0 && n < 50) begin step(0, 0); n++; end
        chk("t3_wait", 32'(n < 50), 1);
        if (gaddr_q.size() > 0) chk("t3_addr", gaddr_q[0], 32'h0000_0100);
        if (popq.size() > 0)    chk("t3_pc", popq[0], 32'h0000_0100);
        #1;
        chk("t3_run", 32'(dut.state), 32'(FETCH_RUN));

        // 5: random stalls, 1000 instructions
        gnt_pct = 70; rv_pct = 70; rdy_pct = 70;
        popq.delete();
        n = 0;
        while (popq.size() < 1000 && n < 20000) begin step(0, 0); n++; end
        chk("t5_wait", 32'(n < 20000), 1);
        for (int i = 1; i < popq.size(); i++) chk("t5_seq", popq[i], popq[i-1] + 32'd4);
        gnt_pct = 100; rv_pct = 100; rdy_pct = 100;

        // 6a: redirect coinciding with pop and response
        lat = 1;
        n = 0;
        #1;
        while (!(valid_o && memq.size() > 0 && memq[0].due <= cycn) && n < 50) begin
            step(0, 0); #1; n++;
        end
        chk("t6a_setup", 32'(n < 50), 1);
        n = popq.size();
        step(1, 32'h0000_0200); #1;
        chk("t6a_pop", 32'(popq.size()), 32'(n + 1));
        chk("t6a_vld_off", 32'(valid_o), 0);
        chk("t6a_run", 32'(dut.state), 32'(FETCH_RUN));
        popq.delete();
        n = 0;
        while (popq.size() == 0 && n < 50) begin step(0, 0); n++; end
        if (popq.size() > 0) chk("t6a_pc", popq[0], 32'h0000_0200);
        else                 chk("t6a_wait", 32'(popq.size()), 1);

        // 6b: reset while draining
        lat = 3;
        n = 0;
        while (!(memq.size() == 2 && memq[0].due > cycn) && n < 50) begin step(0, 0); n++; end
        chk("t6b_setup", 32'(n < 50), 1);
        step(1, 32'h0000_0300); #1;
        chk("t6b_drain", 32'(dut.state), 32'(FETCH_DRAIN));
        rst = 1;
        step(0, 0); #1;
        chk("t6b_vld", 32'(valid_o), 0);
        chk("t6b_req", 32'(imem_req_o), 0);
        chk("t6b_boot", 32'(dut.state), 32'(FETCH_BOOT));
        rst = 0;
        gaddr_q.delete();
        popq.delete();
        n = 0;
        while (popq.size() < 3 && n < 60) begin step(0, 0); n++; end
        chk("t6b_wait", 32'(n < 60), 1);
        if (gaddr_q.size() > 0) chk("t6b_addr", gaddr_q[0], 32'h0);
        if (popq.size() > 0)    chk("t6b_pc", popq[0], 32'h0);

        // 4: wrap from RESET_PC near the top of the address space
        chk("t4_cnt", 32'(b_gq.size() >= 3 && b_pq.size() >= 3), 1);
        if (b_gq.size() >= 3 && b_pq.size() >= 3) begin
            chk("t4_a0", b_gq[0], 32'hFFFF_FFF8);
            chk("t4_a1", b_gq[1], 32'hFFFF_FFFC);
            chk("t4_a2", b_gq[2], 32'h0000_0000);
            chk("t4_p0", b_pq[0], 32'hFFFF_FFF8);
            chk("t4_p2", b_pq[2], 32'h0000_0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
